// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-SRAM req/ready handshake and IF/ID register.
// Bubbles are all-zero (sll nop) with IF_ID_Valid low.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        Stall,
    input  logic        IF_Flush,
    input  logic [1:0]  ID_PCSrc,
    input  logic        ID_Update,
    input  logic [31:0] ID_Target,
    input  logic [31:0] ID_RegTarget,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ready,
    input  logic [31:0] inst_rdata,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_Instruction,
    output logic        IF_ID_Valid
);

    // state | meaning
    // BOOT  | one idle cycle after reset release
    // FETCH | request outstanding at pc
    // DROP  | redirected while waiting; response will be thrown away, then go to pend
    // HOLD  | fetched word parked in hold_q while the pipeline is stalled
    typedef enum logic [1:0] {BOOT, FETCH, DROP, HOLD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend;
    logic [31:0] hold_q;
    logic        redirect;
    logic [31:0] tgt;
    logic [31:0] pc_next;

    assign redirect  = ((ID_PCSrc != 2'b00) || ID_Update) && !Stall;
    assign tgt       = ID_PCSrc[1] ? ID_RegTarget : ID_Target;
    assign pc_next   = pc + 32'd4;
    assign inst_addr = {pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state             <= BOOT;
            pc                <= RESET_PC;
            pend              <= '0;
            hold_q            <= '0;
            inst_req          <= 1'b0;
            IF_ID_PC          <= '0;
            IF_ID_Instruction <= '0;
            IF_ID_Valid       <= 1'b0;
        end else begin
            // Default: bubble unless stalled; the loads below override it.
            if (!Stall) begin
                IF_ID_PC          <= '0;
                IF_ID_Instruction <= '0;
                IF_ID_Valid       <= 1'b0;
            end
            case (state)
                BOOT: begin
                    state    <= FETCH;
                    inst_req <= 1'b1;
                end
                FETCH: begin
                    if (inst_ready) begin
                        if (redirect) begin
                            pc <= tgt;
                        end else if (Stall) begin
                            hold_q   <= inst_rdata;
                            state    <= HOLD;
                            inst_req <= 1'b0;
                        end else begin
                            pc <= pc_next;
                            if (!IF_Flush) begin
                                IF_ID_PC          <= pc;
                                IF_ID_Instruction <= inst_rdata;
                                IF_ID_Valid       <= 1'b1;
                            end
                        end
                    end else if (redirect) begin
                        pend  <= tgt;
                        state <= DROP;
                    end
                end
                DROP: begin
                    if (redirect) pend <= tgt;
                    if (inst_ready) begin
                        pc    <= redirect ? tgt : pend;
                        state <= FETCH;
                    end
                end
                HOLD: begin
                    if (!Stall) begin
                        state    <= FETCH;
                        inst_req <= 1'b1;
                        if (redirect) begin
                            pc <= tgt;
                        end else begin
                            pc <= pc_next;
                            if (!IF_Flush) begin
                                IF_ID_PC          <= pc;
                                IF_ID_Instruction <= hold_q;
                                IF_ID_Valid       <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state    <= BOOT;
                    inst_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle vector table, reset-mid-DROP sequence,
// and a random-ready stream checked through an expected-PC queue.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        Stall = 1'b0;
    logic        IF_Flush = 1'b0;
    logic [1:0]  ID_PCSrc = 2'b00;
    logic        ID_Update = 1'b0;
    logic [31:0] ID_Target = '0;
    logic [31:0] ID_RegTarget = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_rdata;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Instruction;
    logic        IF_ID_Valid;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .resetn(resetn), .Stall(Stall), .IF_Flush(IF_Flush),
        .ID_PCSrc(ID_PCSrc), .ID_Update(ID_Update), .ID_Target(ID_Target),
        .ID_RegTarget(ID_RegTarget), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_ready(inst_ready), .inst_rdata(inst_rdata), .IF_ID_PC(IF_ID_PC),
        .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_Valid(IF_ID_Valid)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'h3C1D_0000 ^ {a[15:0], a[31:16]};
    endfunction

    assign inst_rdata = mem_fn(inst_addr);

    typedef struct {
        logic        stall;
        logic        flush;
        logic [1:0]  pcsrc;
        logic        upd;
        logic [31:0] t;
        logic [31:0] rt;
        logic        rdy;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          total = 0;
    int          passed = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add(input logic s, input logic f, input logic [1:0] ps, input logic u,
                       input logic [31:0] t, input logic [31:0] rt, input logic r,
                       input logic er, input logic [31:0] ea, input logic ev,
                       input logic [31:0] ep);
        vec_t v;
        v = '{stall: s, flush: f, pcsrc: ps, upd: u, t: t, rt: rt, rdy: r,
              exp_req: er, exp_addr: ea, exp_valid: ev, exp_pc: ep};
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v);
        Stall        = v.stall;
        IF_Flush     = v.flush;
        ID_PCSrc     = v.pcsrc;
        ID_Update    = v.upd;
        ID_Target    = v.t;
        ID_RegTarget = v.rt;
        inst_ready   = v.rdy;
    endtask

    task automatic idle(input logic rdy);
        Stall = 1'b0; IF_Flush = 1'b0; ID_PCSrc = 2'b00; ID_Update = 1'b0;
        ID_Target = '0; ID_RegTarget = '0; inst_ready = rdy;
    endtask

    task automatic check_out(input string tag, input logic er, input logic [31:0] ea,
                             input logic ev, input logic [31:0] ep);
        chk({tag, " req"}, {31'd0, inst_req}, {31'd0, er});
        if (er) chk({tag, " addr"}, inst_addr, ea);
        chk({tag, " valid"}, {31'd0, IF_ID_Valid}, {31'd0, ev});
        if (ev) begin
            chk({tag, " pc"}, IF_ID_PC, ep);
            chk({tag, " instr"}, IF_ID_Instruction, mem_fn(ep));
        end else begin
            chk({tag, " bubble instr"}, IF_ID_Instruction, 32'd0);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " req"}, {31'd0, inst_req}, 32'd0);
        chk({tag, " addr"}, inst_addr, 32'h8000_0000);
        chk({tag, " valid"}, {31'd0, IF_ID_Valid}, 32'd0);
        chk({tag, " pc"}, IF_ID_PC, 32'd0);
        chk({tag, " instr"}, IF_ID_Instruction, 32'd0);
    endtask

    localparam logic [31:0] B = 32'h8000_0000;
    localparam logic [31:0] DECOY = 32'h1234_5670;

    initial begin
        logic        accept;
        logic [31:0] exp_next;
        logic [31:0] popped;

        //   st fl pcsrc up  t          rt          rdy  req addr          v  pc
        add(0, 0, 2'b00, 0, 0,         0,          1,   1,  B,            0, 0);
        add(0, 0, 2'b00, 0, 0,         0,          1,   1,  B+4,          1, B);
        add(1, 0, 2'b00, 0, 0,         0,          1,   1,  B+8,          1, B+4);
        add(1, 0, 2'b00, 0, 0,         0,          1,   0,  0,            1, B+4);
        add(0, 0, 2'b00, 0, 0,         0,          1,   0,  0,            1, B+4);
        add(0, 0, 2'b00, 0, 0,         0,          0,   1,  B+12,         1, B+8);
        add(0, 0, 2'b01, 0, B+'h100,   DECOY,      0,   1,  B+12,         0, 0);
        add(0, 0, 2'b00, 0, 0,         0,          1,   1,  B+12,         0, 0);
        add(0, 0, 2'b00, 0, 0,         0,          1,   1,  B+'h100,      0, 0);
        add(0, 0, 2'b10, 0, DECOY,     B+'h200,    1,   1,  B+'h104,      1, B+'h100);
        add(0, 1, 2'b00, 0, 0,         0,          1,   1,  B+'h200,      0, 0);
        add(0, 0, 2'b00, 1, B+'h300,   DECOY,      1,   1,  B+'h204,      0, 0);
        add(1, 1, 2'b00, 0, 0,         0,          1,   1,  B+'h300,      0, 0);
        add(0, 0, 2'b01, 0, B+'h400,   DECOY,      0,   0,  0,            0, 0);
        add(0, 0, 2'b00, 0, 0,         0,          1,   1,  B+'h400,      0, 0);
        add(1, 0, 2'b01, 0, B+'h500,   DECOY,      1,   1,  B+'h404,      1, B+'h400);
        add(0, 0, 2'b00, 0, 0,         0,          1,   0,  0,            1, B+'h400);
        add(0, 0, 2'b01, 0, B+'h600,   DECOY,      0,   1,  B+'h408,      1, B+'h404);
        add(0, 0, 2'b01, 0, B+'h700,   DECOY,      0,   1,  B+'h408,      0, 0);
        add(0, 0, 2'b00, 0, 0,         0,          1,   1,  B+'h408,      0, 0);
        add(0, 0, 2'b10, 0, DECOY,     32'hFFFF_FFFC, 1, 1, B+'h700,      0, 0);
        add(0, 0, 2'b00, 0, 0,         0,          1,   1,  32'hFFFF_FFFC, 0, 0);
        add(0, 0, 2'b00, 0, 0,         0,          0,   1,  32'h0,        1, 32'hFFFF_FFFC);
        add(0, 0, 2'b01, 0, B+'h900,   DECOY,      0,   1,  32'h0,        0, 0);

        // Reset state, then table-driven cycles
        idle(1'b0);
        @(negedge clk);
        check_reset("reset");
        resetn = 1'b1;
        idle(1'b1);
        #1 chk("boot req", {31'd0, inst_req}, 32'd0);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vecs[i].exp_req, vecs[i].exp_addr,
                      vecs[i].exp_valid, vecs[i].exp_pc);
            apply(vecs[i]);
        end

        // Reset while in DROP with a pending redirect to B+0x900
        @(negedge clk);
        check_out("drop before reset", 1'b1, 32'h0, 1'b0, 32'h0);
        idle(1'b0);
        #2 resetn = 1'b0;
        #1 check_reset("async reset");
        @(negedge clk);
        resetn = 1'b1;
        idle(1'b1);
        #1 chk("reboot req", {31'd0, inst_req}, 32'd0);
        @(negedge clk);
        check_out("reboot fetch0", 1'b1, B, 1'b0, 32'h0);
        @(negedge clk);
        check_out("reboot fetch1", 1'b1, B + 4, 1'b1, B);

        // Random-ready stream: every accepted fetch appears exactly once, in order
        idle(1'b0);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        exp_next = B;
        accept = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (accept) begin
                chk("stream valid", {31'd0, IF_ID_Valid}, 32'd1);
                popped = exp_q.pop_front();
                chk("stream pc", IF_ID_PC, popped);
                chk("stream instr", IF_ID_Instruction, mem_fn(popped));
            end else begin
                chk("stream bubble", {31'd0, IF_ID_Valid}, 32'd0);
            end
            if (inst_req) chk("stream addr", inst_addr, exp_next);
            inst_ready = 1'($urandom_range(0, 1));
            accept = inst_req && inst_ready;
            if (accept) begin
                exp_q.push_back(exp_next);
                exp_next = exp_next + 32'd4;
            end
        end
        @(negedge clk);
        if (accept) begin
            popped = exp_q.pop_front();
            chk("stream last pc", IF_ID_PC, popped);
        end
        chk("stream queue empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
